scoreboard_cam: RTL and testbench

Parametrised key/value scoreboard holding up to DEPTH tagged entries with per-entry valid bits. Supports lookup, insert/update and per-key flush through a single-command handshake, plus whole-table clear. It searches LANES entries per cycle, so designs trade area for latency. It sits between the processor dispatch logic and the processor array, tracking which processor slot owns which task key.

---
 rtl/scoreboard_pkg.sv | 17 +
 rtl/scoreboard_match_lane.sv | 36 +++
 rtl/scoreboard_cam.sv | 235 +++++++++++++++++++++++
 tb/tb_scoreboard_cam.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and default sizes for the scoreboard CAM (optional feature: SCOREBOARD_OVERWRITE_EN).
package scoreboard_pkg;

  typedef enum logic [1:0] {CMD_READ, CMD_WRITE, CMD_FLUSH} cmd_e;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefKeyW  = 16;
  localparam int unsigned DefValW  = 8;
  localparam int unsigned DefLanes = 1;

  // $clog2 that never returns 0, so single-element selects still get a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scoreboard_match_lane.sv
// Combinational compare of one group of LANES entries: lowest-index hit and lowest-index free slot.
module scoreboard_match_lane
  import scoreboard_pkg::*;
#(
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned KEY_W = DefKeyW,
  localparam int unsigned OFF_W = clog2_min1(LANES)
) (
  input  logic [KEY_W-1:0]       key_i,
  input  logic [LANES*KEY_W-1:0] keys_i,
  input  logic [LANES-1:0]       valid_i,
  output logic                   hit_o,
  output logic [OFF_W-1:0]       hit_off_o,
  output logic                   free_o,
  output logic [OFF_W-1:0]       free_off_o
);

  // Walk high to low so the lowest matching lane is the one left standing.
  always_comb begin
    hit_o      = 1'b0;
    hit_off_o  = '0;
    free_o     = 1'b0;
    free_off_o = '0;
    for (int l = int'(LANES) - 1; l >= 0; l--) begin
      if (valid_i[l] && (keys_i[l*KEY_W +: KEY_W] == key_i)) begin
        hit_o     = 1'b1;
        hit_off_o = OFF_W'(l);
      end
      if (!valid_i[l]) begin
        free_o     = 1'b1;
        free_off_o = OFF_W'(l);
      end
    end
  end

endmodule

// File: rtl/scoreboard_cam.sv
// Key/value scoreboard scanning LANES entries per cycle; SCOREBOARD_OVERWRITE_EN enables
// round-robin replacement on a write to a full table.
module scoreboard_cam
  import scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned KEY_W = DefKeyW,
  parameter int unsigned VAL_W = DefValW,
  parameter int unsigned LANES = DefLanes,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned NGRP  = DEPTH / LANES,
  localparam int unsigned GRP_W = clog2_min1(NGRP),
  localparam int unsigned OFF_W = clog2_min1(LANES)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [KEY_W-1:0] i_key,
  input  logic [VAL_W-1:0] i_val,
  input  logic             i_read,
  input  logic             i_write,
  input  logic             i_flush,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_ack,
  output logic             o_exists,
  output logic [VAL_W-1:0] o_val,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_err,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } entry_t;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_sel;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [GRP_W-1:0] grp_q;
  logic             free_found_q;
  logic [IDX_W-1:0] free_idx_q;
  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             exists_q, exists_d;
  logic [VAL_W-1:0] rval_q, rval_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic [LANES*KEY_W-1:0] lane_keys;
  logic [LANES-1:0]       lane_valid;
  logic                   lane_hit, lane_free;
  logic [OFF_W-1:0]       hit_off, free_off;
  logic [IDX_W-1:0]       base_idx, hit_idx, free_lane_idx, free_sel, wr_idx;
  logic                   any_req, accept, last_grp, commit, free_any, wr_en;

`ifdef SCOREBOARD_OVERWRITE_EN
  logic [IDX_W-1:0] victim_q, victim_d;
`endif

  assign any_req  = i_read | i_write | i_flush;
  assign cmd_sel  = i_flush ? CMD_FLUSH : (i_write ? CMD_WRITE : CMD_READ);
  // A command may also be taken on the edge that ends the ack cycle.
  assign accept   = ((state_q == IDLE) || (state_q == RESP)) && any_req && !i_clear;
  assign last_grp = (grp_q == GRP_W'(NGRP - 1));
  assign commit   = (state_q == SCAN) && (lane_hit || last_grp) && !i_clear;

  assign base_idx      = IDX_W'(grp_q * LANES);
  assign hit_idx       = base_idx + IDX_W'(hit_off);
  assign free_lane_idx = base_idx + IDX_W'(free_off);
  assign free_any      = free_found_q | lane_free;
  assign free_sel      = free_found_q ? free_idx_q : free_lane_idx;

  always_comb begin
    lane_keys  = '0;
    lane_valid = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_keys[l*KEY_W +: KEY_W] = ent_q[base_idx + IDX_W'(l)].key;
      lane_valid[l]               = valid_q[base_idx + IDX_W'(l)];
    end
  end

  scoreboard_match_lane #(
    .LANES (LANES),
    .KEY_W (KEY_W)
  ) u_match (
    .key_i      (key_q),
    .keys_i     (lane_keys),
    .valid_i    (lane_valid),
    .hit_o      (lane_hit),
    .hit_off_o  (hit_off),
    .free_o     (lane_free),
    .free_off_o (free_off)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SCAN;
      SCAN:    if (lane_hit || last_grp) state_d = RESP;
      RESP:    state_d = any_req ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = hit_idx;
    valid_d  = valid_q;
    count_d  = count_q;
    exists_d = 1'b0;
    rval_d   = '0;
    idx_d    = '0;
    err_d    = 1'b0;
`ifdef SCOREBOARD_OVERWRITE_EN
    victim_d = victim_q;
`endif
    unique case (cmd_q)
      CMD_READ: begin
        if (lane_hit) begin
          exists_d = 1'b1;
          rval_d   = ent_q[hit_idx].val;
          idx_d    = hit_idx;
        end
      end
      CMD_WRITE: begin
        if (lane_hit) begin
          wr_en    = 1'b1;
          exists_d = 1'b1;
          idx_d    = hit_idx;
        end else if (free_any) begin
          wr_en            = 1'b1;
          wr_idx           = free_sel;
          valid_d[free_sel] = 1'b1;
          idx_d            = free_sel;
          count_d          = count_q + 1'b1;
        end else begin
`ifdef SCOREBOARD_OVERWRITE_EN
          wr_en    = 1'b1;
          wr_idx   = victim_q;
          idx_d    = victim_q;
          victim_d = victim_q + 1'b1;
`else
          err_d = 1'b1;
`endif
        end
      end
      CMD_FLUSH: begin
        if (lane_hit) begin
          valid_d[hit_idx] = 1'b0;
          exists_d         = 1'b1;
          idx_d            = hit_idx;
          count_d          = count_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_q        <= CMD_READ;
      key_q        <= '0;
      val_q        <= '0;
      grp_q        <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      valid_q      <= '0;
      count_q      <= '0;
      exists_q     <= 1'b0;
      rval_q       <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q        <= cmd_sel;
        key_q        <= i_key;
        val_q        <= i_val;
        grp_q        <= '0;
        free_found_q <= 1'b0;
      end else if (state_q == SCAN) begin
        grp_q <= grp_q + 1'b1;
        if (!free_found_q && lane_free) begin
          free_found_q <= 1'b1;
          free_idx_q   <= free_lane_idx;
        end
      end
      if (commit) begin
        valid_q  <= valid_d;
        count_q  <= count_d;
        exists_q <= exists_d;
        rval_q   <= rval_d;
        idx_q    <= idx_d;
        err_q    <= err_d;
      end
      if (i_clear) begin
        valid_q <= '0;
        count_q <= '0;
      end
    end
  end

`ifdef SCOREBOARD_OVERWRITE_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       victim_q <= '0;
    else if (commit) victim_q <= victim_d;
  end
`endif

  // Payload storage needs no reset; valid_q qualifies every read.
  always_ff @(posedge i_clk) begin
    if (commit && wr_en) ent_q[wr_idx] <= {key_q, val_q};
  end

  assign o_busy   = (state_q != IDLE);
  assign o_ack    = (state_q == RESP);
  assign o_exists = exists_q;
  assign o_val    = rval_q;
  assign o_idx    = idx_q;
  assign o_err    = err_q;
  assign o_count  = count_q;
  assign o_full   = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_scoreboard_cam.sv
// Bench for scoreboard_cam: LANES=1 and LANES=2 instances share stimulus and one reference table;
// honours SCOREBOARD_OVERWRITE_EN when defined.
module tb_scoreboard_cam;
  localparam int DEPTH = 4;
  localparam int KEY_W = 16;
  localparam int VAL_W = 8;
  localparam int IW    = 2;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst, rd, wr, fl, clr;
  logic [KEY_W-1:0] key;
  logic [VAL_W-1:0] val;
  logic [1:0] busy, ack, exists, err, full;
  logic [1:0][VAL_W-1:0] oval;
  logic [1:0][IW-1:0] idx;
  logic [1:0][CW-1:0] cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scoreboard_cam #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W), .LANES(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_val(val), .i_read(rd), .i_write(wr),
    .i_flush(fl), .i_clear(clr), .o_busy(busy[0]), .o_ack(ack[0]), .o_exists(exists[0]),
    .o_val(oval[0]), .o_idx(idx[0]), .o_err(err[0]), .o_full(full[0]), .o_count(cnt[0])
  );

  scoreboard_cam #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W), .LANES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_val(val), .i_read(rd), .i_write(wr),
    .i_flush(fl), .i_clear(clr), .o_busy(busy[1]), .o_ack(ack[1]), .o_exists(exists[1]),
    .o_val(oval[1]), .o_idx(idx[1]), .o_err(err[1]), .o_full(full[1]), .o_count(cnt[1])
  );

  // Reference table: plain arrays, lowest-index search, latency from the hit position.
  logic [KEY_W-1:0] mkey [DEPTH];
  logic [VAL_W-1:0] mval [DEPTH];
  bit               mvld [DEPTH];
  int               mvic = 0;
  bit               e_ex, e_err;
  logic [VAL_W-1:0] e_val;
  int               e_idx;
  int               e_lat [2];

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mvld[i]);
    return c;
  endfunction

  task automatic model_clear(input bit rst_too);
    for (int i = 0; i < DEPTH; i++) mvld[i] = 1'b0;
    if (rst_too) mvic = 0;
  endtask

  task automatic model_cmd(input int c, input int k, input int v);
    int h = -1;
    int f = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (h < 0 && mvld[i] && mkey[i] == KEY_W'(k)) h = i;
      if (f < 0 && !mvld[i]) f = i;
    end
    e_ex  = (h >= 0);
    e_err = 1'b0;
    e_val = '0;
    e_idx = 0;
    for (int d = 0; d < 2; d++) e_lat[d] = ((h >= 0) ? h / (d + 1) + 1 : DEPTH / (d + 1)) + 1;
    if (c == 0) begin
      if (h >= 0) begin e_val = mval[h]; e_idx = h; end
    end else if (c == 1) begin
      if (h >= 0) begin
        mval[h] = VAL_W'(v); e_idx = h;
      end else if (f >= 0) begin
        mvld[f] = 1'b1; mkey[f] = KEY_W'(k); mval[f] = VAL_W'(v); e_idx = f;
      end else begin
`ifdef SCOREBOARD_OVERWRITE_EN
        mkey[mvic] = KEY_W'(k); mval[mvic] = VAL_W'(v); e_idx = mvic; mvic = (mvic + 1) % DEPTH;
`else
        e_err = 1'b1;
`endif
      end
    end else begin
      if (h >= 0) begin mvld[h] = 1'b0; e_idx = h; end
    end
  endtask

  // Issues one command and returns the ack cycle of each instance (0 = none within 20 cycles).
  task automatic do_cmd(input int c, input int k, input int v, output int l0, output int l1);
    @(negedge clk);
    key = KEY_W'(k); val = VAL_W'(v);
    rd = (c == 0); wr = (c == 1); fl = (c == 2);
    l0 = 0; l1 = 0;
    for (int n = 1; n <= 20 && (l0 == 0 || l1 == 0); n++) begin
      @(negedge clk);
      if (n == 1) begin rd = 0; wr = 0; fl = 0; end
      if (l0 == 0 && ack[0]) l0 = n;
      if (l1 == 0 && ack[1]) l1 = n;
    end
  endtask

  task automatic test_reset();
    rst = 1; rd = 0; wr = 0; fl = 0; clr = 0; key = '0; val = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if ({busy[d], ack[d], exists[d], err[d], full[d]} !== 5'b0) begin
        errors++; $display("FAIL reset flags dut%0d: got %b want 00000", d,
                           {busy[d], ack[d], exists[d], err[d], full[d]});
      end
      if (cnt[d] !== '0) begin
        errors++; $display("FAIL reset count dut%0d: got %0d want 0", d, cnt[d]);
      end
      if ({oval[d], idx[d]} !== '0) begin
        errors++; $display("FAIL reset val/idx dut%0d: got %0d/%0d want 0/0", d, oval[d], idx[d]);
      end
    end
  endtask

  task automatic test_directed();
    // cmd: 0 read, 1 write, 2 flush
    int oc [14] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 2, 1, 2};
    int ok [14] = '{4, 6, 8, 8, 5, 6, 6, 10, 12, 12, 4, 6, 14, 6};
    int ov [14] = '{1, 2, 3, 0, 0, 9, 0, 7, 5, 0, 0, 0, 1, 0};
    int lat [2];
    for (int i = 0; i < 14; i++) begin
      model_cmd(oc[i], ok[i], ov[i]);
      do_cmd(oc[i], ok[i], ov[i], lat[0], lat[1]);
      for (int d = 0; d < 2; d++) begin
        checks += 5;
        if (lat[d] !== e_lat[d]) begin
          errors++; $display("FAIL dir ack-cycle op%0d dut%0d: got %0d want %0d", i, d, lat[d], e_lat[d]);
        end
        if (exists[d] !== e_ex) begin
          errors++; $display("FAIL dir exists op%0d dut%0d: got %b want %b", i, d, exists[d], e_ex);
        end
        if (err[d] !== e_err) begin
          errors++; $display("FAIL dir err op%0d dut%0d: got %b want %b", i, d, err[d], e_err);
        end
        if (int'(cnt[d]) != mcount()) begin
          errors++; $display("FAIL dir count op%0d dut%0d: got %0d want %0d", i, d, cnt[d], mcount());
        end
        if (full[d] !== (mcount() == DEPTH)) begin
          errors++; $display("FAIL dir full op%0d dut%0d: got %b want %b", i, d, full[d], mcount() == DEPTH);
        end
        if (oc[i] == 0) begin
          checks++;
          if (oval[d] !== e_val) begin
            errors++; $display("FAIL dir val op%0d dut%0d: got %0d want %0d", i, d, oval[d], e_val);
          end
        end
        if (!e_err) begin
          checks++;
          if (int'(idx[d]) != e_idx) begin
            errors++; $display("FAIL dir idx op%0d dut%0d: got %0d want %0d", i, d, idx[d], e_idx);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int W = 12;
    int nack [2] = '{0, 0};
    int first [2] = '{0, 0};
    model_cmd(0, 8, 0);
    @(negedge clk);
    key = KEY_W'(8); rd = 1;
    for (int n = 1; n <= W; n++) begin
      @(negedge clk);
      if (n == W) rd = 0;
      for (int d = 0; d < 2; d++) if (ack[d]) begin
        nack[d]++;
        if (first[d] == 0) first[d] = n;
      end
    end
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 3;
      if (nack[d] != W / e_lat[d]) begin
        errors++; $display("FAIL b2b ack-count dut%0d: got %0d want %0d", d, nack[d], W / e_lat[d]);
      end
      if (first[d] != e_lat[d]) begin
        errors++; $display("FAIL b2b first-ack dut%0d: got %0d want %0d", d, first[d], e_lat[d]);
      end
      if (oval[d] !== e_val) begin
        errors++; $display("FAIL b2b val dut%0d: got %0d want %0d", d, oval[d], e_val);
      end
    end
  endtask

  task automatic test_abort(input bit use_rst);
    int nack = 0;
    int lat [2];
    if (mcount() == 0) begin
      model_cmd(1, 3, 3);
      do_cmd(1, 3, 3, lat[0], lat[1]);
    end
    @(negedge clk);
    key = KEY_W'(16'hbeef); rd = 1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) rd = 0;
      if (n == 2) begin
        if (use_rst) rst = 1; else clr = 1;
        #1;
        if (use_rst) begin
          checks++;
          if (busy !== 2'b00 || cnt !== '0) begin
            errors++; $display("FAIL rst-abort immediate: got busy=%b cnt=%h want busy=00 cnt=0", busy, cnt);
          end
        end
      end
      if (n == 3) begin
        rst = 0; clr = 0;
        checks++;
        if (busy !== 2'b00 || cnt !== '0) begin
          errors++; $display("FAIL abort(rst=%0d) after: got busy=%b cnt=%h want busy=00 cnt=0", use_rst,
                             busy, cnt);
        end
      end
      nack += int'(ack[0]) + int'(ack[1]);
    end
    checks++;
    if (nack != 0) begin
      errors++; $display("FAIL abort(rst=%0d) ack: got %0d acks want 0", use_rst, nack);
    end
    model_clear(use_rst);
  endtask

  task automatic test_random();
    int lat [2];
    int c, k, v;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        model_clear(1'b0);
        checks++;
        if (cnt !== '0) begin
          errors++; $display("FAIL rnd clear count: got %h want 0", cnt);
        end
      end
      c = int'($urandom_range(0, 2));
      k = int'($urandom_range(0, 5));
      v = int'($urandom_range(0, 255));
      model_cmd(c, k, v);
      do_cmd(c, k, v, lat[0], lat[1]);
      for (int d = 0; d < 2; d++) begin
        checks += 5;
        if (lat[d] !== e_lat[d]) begin
          errors++; $display("FAIL rnd ack-cycle op%0d dut%0d: got %0d want %0d", i, d, lat[d], e_lat[d]);
        end
        if (exists[d] !== e_ex) begin
          errors++; $display("FAIL rnd exists op%0d dut%0d: got %b want %b", i, d, exists[d], e_ex);
        end
        if (err[d] !== e_err) begin
          errors++; $display("FAIL rnd err op%0d dut%0d: got %b want %b", i, d, err[d], e_err);
        end
        if (int'(cnt[d]) != mcount()) begin
          errors++; $display("FAIL rnd count op%0d dut%0d: got %0d want %0d", i, d, cnt[d], mcount());
        end
        if (full[d] !== (mcount() == DEPTH)) begin
          errors++; $display("FAIL rnd full op%0d dut%0d: got %b want %b", i, d, full[d], mcount() == DEPTH);
        end
        if (c == 0) begin
          checks++;
          if (oval[d] !== e_val) begin
            errors++; $display("FAIL rnd val op%0d dut%0d: got %0d want %0d", i, d, oval[d], e_val);
          end
        end
        if (!e_err) begin
          checks++;
          if (int'(idx[d]) != e_idx) begin
            errors++; $display("FAIL rnd idx op%0d dut%0d: got %0d want %0d", i, d, idx[d], e_idx);
          end
        end
      end
    end
  endtask

  initial begin
    model_clear(1'b1);
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
